// File: rtl/oam_dma_arbiter_pkg.sv
// Shared definitions for the OAM DMA arbiter.
//   dma_state_e  : engine states (Idle -> Start -> Active -> Idle)
//   DMA_REG_ADDR : CPU address of the DMA source register
//   DMA_LEN      : bytes copied per transfer (also last OAM index + 1)
//   HIGH_PAGE    : upper address byte of the IO/HRAM page kept by the CPU
//   ECHO_BASE    : first source page that is folded back by 0x20 pages
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    DmaIdle   = 2'd0,
    DmaStart  = 2'd1,
    DmaActive = 2'd2
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          DMA_LEN      = 160;
  localparam logic [7:0]  HIGH_PAGE    = 8'hFF;
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;

  // Source pages E0..FF read through the echo-RAM mirror of C0..DF.
  function automatic logic [7:0] dma_src_hi(input logic [7:0] reg_val);
    return (reg_val >= ECHO_BASE) ? (reg_val - 8'h20) : reg_val;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// Bus bundle around the arbiter: CPU side, main bus, high bus and OAM port.
//   master : the environment (CPU, memories, OAM) - drives CPU requests and
//            read data coming back from the main/high buses.
//   slave  : the arbiter - drives routed bus requests, CPU read data, OAM
//            writes, dma_active and the engine state for observation.
// Handshake: there is no valid/ready pair. A request is qualified by its
// *_enable for the whole M-cycle; *_write selects direction; state and
// memory commits happen only on the clk edge where t_cycle == 3.
interface oam_dma_arbiter_if;
  import oam_dma_arbiter_pkg::*;

  logic [1:0]  t_cycle;
  logic [15:0] cpu_addr;
  logic        cpu_enable;
  logic        cpu_write;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;

  logic [15:0] main_addr;
  logic        main_enable;
  logic        main_write;
  logic [7:0]  main_data_out;
  logic [7:0]  main_data_in;

  logic [7:0]  high_addr;
  logic        high_enable;
  logic        high_write;
  logic [7:0]  high_data_out;
  logic [7:0]  high_data_in;

  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_data;

  logic        dma_active;
  dma_state_e  dma_state;

  modport master (
    output t_cycle, cpu_addr, cpu_enable, cpu_write, cpu_data_out,
    output main_data_in, high_data_in,
    input  cpu_data_in,
    input  main_addr, main_enable, main_write, main_data_out,
    input  high_addr, high_enable, high_write, high_data_out,
    input  oam_addr, oam_write, oam_data, dma_active, dma_state
  );

  modport slave (
    input  t_cycle, cpu_addr, cpu_enable, cpu_write, cpu_data_out,
    input  main_data_in, high_data_in,
    output cpu_data_in,
    output main_addr, main_enable, main_write, main_data_out,
    output high_addr, high_enable, high_write, high_data_out,
    output oam_addr, oam_write, oam_data, dma_active, dma_state
  );

endinterface

// File: rtl/oam_dma_arbiter_engine.sv
// OAM DMA engine: DMA source register, transfer state machine, byte counter
// and the OAM write port.
//   clk, rst_n    : clock, asynchronous active-low reset
//   t_cycle_i     : CPU T-cycle phase, 3 = commit edge
//   trigger_i     : CPU write to the DMA register this M-cycle
//   wdata_i       : CPU write data (new source page)
//   rd_data_i     : main bus read data for the byte being copied
//   state_o       : current engine state
//   dma_reg_o     : DMA register readback (unmodified CPU value)
//   src_addr_o    : main bus address of the byte being copied
//   reading_o     : engine is copying this M-cycle (owns main bus enable)
//   dma_active_o  : CPU must be kept off the main bus
//   oam_addr_o/oam_write_o/oam_data_o : OAM write port
module oam_dma_arbiter_engine
  import oam_dma_arbiter_pkg::*;
#(
  parameter int DMA_LEN = oam_dma_arbiter_pkg::DMA_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  t_cycle_i,
  input  logic        trigger_i,
  input  logic [7:0]  wdata_i,
  input  logic [7:0]  rd_data_i,
  output dma_state_e  state_o,
  output logic [7:0]  dma_reg_o,
  output logic [15:0] src_addr_o,
  output logic        reading_o,
  output logic        dma_active_o,
  output logic [7:0]  oam_addr_o,
  output logic        oam_write_o,
  output logic [7:0]  oam_data_o
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_e state_q;
  logic [7:0] count_q;
  logic [7:0] dma_reg_q;
  logic       restart_q;

  logic commit;
  assign commit = (t_cycle_i == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DmaIdle;
      count_q   <= 8'd0;
      dma_reg_q <= 8'd0;
      restart_q <= 1'b0;
    end else if (commit) begin
      if (trigger_i) begin
        // A trigger wins over everything, including the final byte; the
        // byte being copied this M-cycle is still written (oam_write is
        // combinational on the current state).
        dma_reg_q <= wdata_i;
        state_q   <= DmaStart;
        count_q   <= 8'd0;
        restart_q <= (state_q == DmaActive);
      end else begin
        case (state_q)
          DmaStart: begin
            state_q   <= DmaActive;
            restart_q <= 1'b0;
          end
          DmaActive: begin
            // count holds at the last index instead of wrapping.
            if (count_q == LAST_IDX) begin
              state_q <= DmaIdle;
            end else begin
              count_q <= count_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state_o      = state_q;
  assign dma_reg_o    = dma_reg_q;
  assign src_addr_o   = {dma_src_hi(dma_reg_q), count_q};
  assign reading_o    = (state_q == DmaActive);
  // A restart keeps the bus blocked through its one-M-cycle start delay.
  assign dma_active_o = (state_q == DmaActive) | ((state_q == DmaStart) & restart_q);
  assign oam_addr_o   = count_q;
  assign oam_write_o  = (state_q == DmaActive) & commit;
  assign oam_data_o   = rd_data_i;

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: shares the CPU system bus between the CPU and the OAM DMA
// engine and hosts the DMA source register.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of oam_dma_arbiter_if (CPU side, main bus
//             0x0000-0xFEFF, high bus 0xFF00-0xFFFF, OAM port, dma_active)
// The high page always belongs to the CPU; the main bus belongs to the DMA
// engine while dma_active is set, and blocked CPU accesses read 0xFF with
// writes dropped.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int          DMA_LEN      = oam_dma_arbiter_pkg::DMA_LEN,
  parameter logic [15:0] DMA_REG_ADDR = oam_dma_arbiter_pkg::DMA_REG_ADDR
) (
  input logic              clk,
  input logic              reset_n,
  oam_dma_arbiter_if.slave bus
);

  logic        high_page;
  logic        reg_hit;
  logic        trigger;
  dma_state_e  eng_state;
  logic [7:0]  dma_reg;
  logic [15:0] src_addr;
  logic        reading;
  logic        dma_active;

  assign high_page = (bus.cpu_addr[15:8] == HIGH_PAGE);
  assign reg_hit   = (bus.cpu_addr == DMA_REG_ADDR);
  assign trigger   = bus.cpu_enable & bus.cpu_write & reg_hit;

  oam_dma_arbiter_engine #(
    .DMA_LEN (DMA_LEN)
  ) u_engine (
    .clk          (clk),
    .rst_n        (reset_n),
    .t_cycle_i    (bus.t_cycle),
    .trigger_i    (trigger),
    .wdata_i      (bus.cpu_data_out),
    .rd_data_i    (bus.main_data_in),
    .state_o      (eng_state),
    .dma_reg_o    (dma_reg),
    .src_addr_o   (src_addr),
    .reading_o    (reading),
    .dma_active_o (dma_active),
    .oam_addr_o   (bus.oam_addr),
    .oam_write_o  (bus.oam_write),
    .oam_data_o   (bus.oam_data)
  );

  assign bus.dma_active = dma_active;
  assign bus.dma_state  = eng_state;

  // High bus: pass-through, except the DMA register which lives here.
  always_comb begin
    bus.high_addr     = bus.cpu_addr[7:0];
    bus.high_data_out = bus.cpu_data_out;
    bus.high_enable   = bus.cpu_enable & high_page & ~reg_hit;
    bus.high_write    = bus.cpu_enable & high_page & ~reg_hit & bus.cpu_write;
  end

  // Main bus: the engine while it holds the bus, otherwise the CPU.
  // In a restart's start M-cycle the bus is held but nothing is issued.
  always_comb begin
    bus.main_data_out = bus.cpu_data_out;
    if (dma_active) begin
      bus.main_addr   = src_addr;
      bus.main_enable = reading;
      bus.main_write  = 1'b0;
    end else begin
      bus.main_addr   = bus.cpu_addr;
      bus.main_enable = bus.cpu_enable & ~high_page;
      bus.main_write  = bus.cpu_enable & ~high_page & bus.cpu_write;
    end
  end

  always_comb begin
    if (reg_hit) begin
      bus.cpu_data_in = dma_reg;
    end else if (high_page) begin
      bus.cpu_data_in = bus.high_data_in;
    end else if (dma_active) begin
      bus.cpu_data_in = 8'hFF;
    end else begin
      bus.cpu_data_in = bus.main_data_in;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Testbench for oam_dma_arbiter: randomized CPU traffic around directed DMA
// transfers, checked every clock against a schedule-based model (a trigger
// in M-cycle N means a start M-cycle at N+1 and byte k copied in N+2+k).
module tb_oam_dma_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  oam_dma_arbiter_if bus();

  oam_dma_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- memories seen by the DUT ----------------
  logic [7:0] mem  [0:65535];
  logic [7:0] hram [0:255];

  assign bus.main_data_in = mem[bus.main_addr];
  assign bus.high_data_in = hram[bus.high_addr];

  always @(posedge clk)
    if (bus.high_enable && bus.high_write && bus.t_cycle == 2'd3)
      hram[bus.high_addr] <= bus.high_data_out;

  // ---------------- counters / checker ----------------
  int total = 0;
  int bad   = 0;
  int mcyc  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic phase(input logic [1:0] t);
    @(negedge clk);
    bus.t_cycle = t;
    if (t == 2'd0) mcyc++;
  endtask

  task automatic cpu_mcycle(input logic [15:0] a, input logic en, input logic wr, input logic [7:0] d);
    @(negedge clk);
    bus.t_cycle      = 2'd0;
    mcyc++;
    bus.cpu_addr     = a;
    bus.cpu_enable   = en;
    bus.cpu_write    = wr;
    bus.cpu_data_out = d;
    phase(2'd1);
    phase(2'd2);
    phase(2'd3);
  endtask

  // Random CPU traffic; never writes the DMA register.
  task automatic rand_access();
    int kind;
    kind = $urandom_range(0, 5);
    case (kind)
      0: cpu_mcycle(16'($urandom_range(0, 16'hFEFF)), 1'b1, 1'b0, 8'h00);
      1: cpu_mcycle(16'($urandom_range(0, 16'hFEFF)), 1'b1, 1'b1, 8'($urandom));
      2: cpu_mcycle(16'hFF00 | 16'($urandom_range(0, 255)), 1'b1, 1'b0, 8'h00);
      3: cpu_mcycle(16'hFF80 + 16'($urandom_range(0, 126)), 1'b1, 1'b1, 8'($urandom));
      4: cpu_mcycle(16'($urandom), 1'b0, 1'($urandom), 8'($urandom));
      default: cpu_mcycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    endcase
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) rand_access();
  endtask

  // ---------------- behavioural model + compare process ----------------
  bit         trig_valid = 1'b0;
  int         trig_m = 0;
  bit         trig_rst = 1'b0;
  logic [7:0] m_reg = 8'h00;
  logic [7:0] m_src = 8'h00;

  // observed OAM writes, for the literal checks
  logic [7:0] oam_shadow [0:255];
  int         wr_cnt = 0;
  int         first_m = 0;
  int         last_m = 0;

  initial begin : compare
    int         m;
    logic [1:0] tc;
    bit         in_xfer, in_start, e_act, hi, isreg, e_men, e_mwr, e_hen;
    logic [7:0] k, e_rd;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      #2;
      tc = bus.t_cycle;
      m  = mcyc;
      if (!reset_n) begin
        trig_valid = 1'b0;
        m_reg      = 8'h00;
      end
      in_xfer  = trig_valid && (m >= trig_m + 2) && (m <= trig_m + 161);
      in_start = trig_valid && (m == trig_m + 1);
      k        = 8'(m - trig_m - 2);
      e_act    = in_xfer || (in_start && trig_rst);
      a        = bus.cpu_addr;
      hi       = (a[15:8] == 8'hFF);
      isreg    = (a == 16'hFF46);

      check("dma_active", 16'(bus.dma_active), 16'(e_act));
      check("oam_write", 16'(bus.oam_write), 16'(in_xfer && tc == 2'd3));
      if (in_xfer && tc == 2'd3) begin
        check("oam_addr", 16'(bus.oam_addr), 16'(k));
        check("oam_data", 16'(bus.oam_data), 16'(mem[{m_src, k}]));
      end

      if (in_xfer) begin
        e_men = 1'b1;
        e_mwr = 1'b0;
      end else if (e_act) begin
        e_men = 1'b0;
        e_mwr = 1'b0;
      end else begin
        e_men = bus.cpu_enable && !hi;
        e_mwr = bus.cpu_enable && !hi && bus.cpu_write;
      end
      check("main_enable", 16'(bus.main_enable), 16'(e_men));
      check("main_write", 16'(bus.main_write), 16'(e_mwr));
      if (e_men) check("main_addr", bus.main_addr, in_xfer ? {m_src, k} : a);
      if (e_mwr) check("main_data_out", 16'(bus.main_data_out), 16'(bus.cpu_data_out));

      e_hen = bus.cpu_enable && hi && !isreg;
      check("high_enable", 16'(bus.high_enable), 16'(e_hen));
      check("high_write", 16'(bus.high_write), 16'(e_hen && bus.cpu_write));
      if (e_hen) check("high_addr", 16'(bus.high_addr), 16'(a[7:0]));

      if (isreg)      e_rd = m_reg;
      else if (hi)    e_rd = hram[a[7:0]];
      else if (e_act) e_rd = 8'hFF;
      else            e_rd = mem[a];
      check("cpu_data_in", 16'(bus.cpu_data_in), 16'(e_rd));

      if (bus.oam_write) begin
        wr_cnt++;
        oam_shadow[bus.oam_addr] = bus.oam_data;
        if (wr_cnt == 1) first_m = m;
        last_m = m;
      end

      if (reset_n && tc == 2'd3 && bus.cpu_enable && bus.cpu_write && isreg) begin
        trig_rst   = in_xfer;
        trig_valid = 1'b1;
        trig_m     = m;
        m_reg      = bus.cpu_data_out;
        m_src      = (m_reg >= 8'hE0) ? (m_reg - 8'h20) : m_reg;
      end
    end
  end

  // ---------------- stimulus ----------------
  int n0;

  initial begin : driver
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) hram[i] = 8'($urandom);
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    mem[16'hD000] = 8'hA7;
    mem[16'h0000] = 8'h42;
    bus.t_cycle      = 2'd0;
    bus.cpu_addr     = 16'h0000;
    bus.cpu_enable   = 1'b0;
    bus.cpu_write    = 1'b0;
    bus.cpu_data_out = 8'h00;

    // reset state
    cpu_mcycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    #2;
    check("reset_dma_active", 16'(bus.dma_active), 16'h0);
    check("reset_oam_write", 16'(bus.oam_write), 16'h0);
    check("reset_ff46", 16'(bus.cpu_data_in), 16'h00);
    reset_n = 1'b1;
    rand_run(3);

    // transfer from C1 with directed blocked/high-bus accesses
    wr_cnt = 0;
    cpu_mcycle(16'hFF46, 1'b1, 1'b1, 8'hC1);
    n0 = mcyc;
    cpu_mcycle(16'h0000, 1'b0, 1'b0, 8'h00);
    cpu_mcycle(16'h0150, 1'b1, 1'b0, 8'h00);
    #2;
    check("blocked_read", 16'(bus.cpu_data_in), 16'hFF);
    cpu_mcycle(16'hC000, 1'b1, 1'b1, 8'h99);
    #2;
    check("blocked_write", 16'(bus.main_write), 16'h0);
    cpu_mcycle(16'hFF80, 1'b1, 1'b1, 8'h3C);
    cpu_mcycle(16'hFF80, 1'b1, 1'b0, 8'h00);
    #2;
    check("hram_readback", 16'(bus.cpu_data_in), 16'h3C);
    rand_run(157);
    #2;
    check("idle_at_n162", 16'(bus.dma_active), 16'h0);
    check("xfer_count", 16'(wr_cnt), 16'd160);
    check("first_pulse_mcycle", 16'(first_m - n0), 16'd2);
    check("last_pulse_mcycle", 16'(last_m - n0), 16'd161);
    check("oam0", 16'(oam_shadow[0]), 16'h5A);
    check("oam37", 16'(oam_shadow[37]), 16'h7F);
    check("oam159", 16'(oam_shadow[159]), 16'hC5);
    rand_run(2);

    // echo-mapped source E2 -> C2xx
    cpu_mcycle(16'hFF46, 1'b1, 1'b1, 8'hE2);
    cpu_mcycle(16'h0000, 1'b0, 1'b0, 8'h00);
    cpu_mcycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    #2;
    check("ff46_readback", 16'(bus.cpu_data_in), 16'h00E2);
    check("echo_main_addr", bus.main_addr, 16'hC200);
    rand_run(163);

    // restart at count 50
    cpu_mcycle(16'hFF46, 1'b1, 1'b1, 8'hC0);
    rand_run(51);
    cpu_mcycle(16'hFF46, 1'b1, 1'b1, 8'hD0);
    cpu_mcycle(16'h0150, 1'b1, 1'b0, 8'h00);
    #2;
    check("restart_hold", 16'(bus.dma_active), 16'h1);
    check("restart_start_nowrite", 16'(bus.oam_write), 16'h0);
    check("restart_start_read", 16'(bus.cpu_data_in), 16'hFF);
    cpu_mcycle(16'h0000, 1'b0, 1'b0, 8'h00);
    #2;
    check("restart_wr", 16'(bus.oam_write), 16'h1);
    check("restart_addr", 16'(bus.oam_addr), 16'h0);
    check("restart_data", 16'(bus.oam_data), 16'hA7);

    // reset in the middle of the count 80 M-cycle
    rand_run(79);
    @(negedge clk);
    bus.t_cycle      = 2'd0;
    mcyc++;
    bus.cpu_addr     = 16'h0000;
    bus.cpu_enable   = 1'b1;
    bus.cpu_write    = 1'b0;
    phase(2'd1);
    phase(2'd2);
    phase(2'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_oam_write", 16'(bus.oam_write), 16'h0);
    check("rst_dma_active", 16'(bus.dma_active), 16'h0);
    check("rst_main_en", 16'(bus.main_enable), 16'h1);
    check("rst_main_addr", bus.main_addr, 16'h0000);
    check("rst_read0", 16'(bus.cpu_data_in), 16'h42);
    cpu_mcycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    #2;
    check("rst_ff46", 16'(bus.cpu_data_in), 16'h00);
    reset_n = 1'b1;
    cpu_mcycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    #2;
    check("post_rst_ff46", 16'(bus.cpu_data_in), 16'h00);
    rand_run(4);

    // trigger coincident with the final byte
    cpu_mcycle(16'hFF46, 1'b1, 1'b1, 8'hC1);
    rand_run(160);
    cpu_mcycle(16'hFF46, 1'b1, 1'b1, 8'hC1);
    #2;
    check("last_write", 16'(bus.oam_write), 16'h1);
    check("last_addr", 16'(bus.oam_addr), 16'd159);
    check("last_data", 16'(bus.oam_data), 16'hC5);
    cpu_mcycle(16'h0000, 1'b0, 1'b0, 8'h00);
    #2;
    check("coinc_start_active", 16'(bus.dma_active), 16'h1);
    check("coinc_start_nowrite", 16'(bus.oam_write), 16'h0);
    cpu_mcycle(16'h0000, 1'b0, 1'b0, 8'h00);
    #2;
    check("coinc_first_addr", 16'(bus.oam_addr), 16'h0);
    check("coinc_first_data", 16'(bus.oam_data), 16'h5A);
    rand_run(165);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the CPU's single system bus and shares it between the CPU and the OAM DMA engine.
- Hosts the DMA register at 0xFF46. A CPU write to 0xFF46 copies 160 bytes from {src,00}..{src,9F} into OAM over 161 M-cycles.
- During the copy, DMA owns the main bus (0x0000-0xFEFF). The CPU keeps the high bus (0xFF00-0xFFFF: IO/HRAM). Blocked CPU main-bus accesses read 0xFF, and their writes are dropped.
- Sits between cpu and the address decoder; M-cycle phase comes from the CPU's t_cycle.

Parameters:
- DMA_LEN, 160, bytes per transfer; also the final OAM index + 1.
- DMA_REG_ADDR, 16'hFF46, address of the DMA source register.

Ports:
- clk  in  1  system clock (4 MHz)
- reset_n  in  1  asynchronous active-low reset
- t_cycle  in  2  CPU T-cycle phase; 3 = last T-cycle of the M-cycle (commit edge)
- cpu_addr  in  16  CPU bus address
- cpu_enable  in  1  CPU access enable
- cpu_write  in  1  CPU write enable
- cpu_data_out  in  8  CPU write data
- cpu_data_in  out  8  read data returned to CPU
- main_addr  out  16  main bus address (0x0000-0xFEFF)
- main_enable  out  1  main bus enable
- main_write  out  1  main bus write
- main_data_out  out  8  main bus write data
- main_data_in  in  8  main bus read data
- high_addr  out  8  high bus offset (cpu_addr[7:0])
- high_enable  out  1  high bus enable
- high_write  out  1  high bus write
- high_data_out  out  8  high bus write data
- high_data_in  in  8  high bus read data
- oam_addr  out  8  OAM byte index 0..159
- oam_write  out  1  OAM write strobe (one clk)
- oam_data  out  8  OAM write data
- dma_active  out  1  DMA owns the main bus

Behaviour:
- Reset (async, reset_n=0):
  - state=Idle, count=0, dma_reg=0, restart flag=0.
  - All enables, writes and oam_write are 0; dma_active=0.
  - This applies mid-transfer too: the transfer is abandoned and no further OAM writes occur.
- States: Idle, Start, Active. All state, count and register updates happen on posedge clk with t_cycle==3.
- Trigger: cpu_enable & cpu_write & cpu_addr==DMA_REG_ADDR at t_cycle==3.
  - dma_reg <= cpu_data_out.
  - state <= Start, count <= 0, from any state.
  - restart <= (state==Active).
  - The trigger write is not forwarded to the high bus.
- Start lasts exactly one M-cycle, then goes to Active. No transfer is performed in Start.
- Active, each M-cycle:
  - main_addr = {src_hi, count}, main_enable=1, main_write=0.
  - At t_cycle==3: oam_write=1, oam_addr=count, oam_data=main_data_in; count <= count+1.
  - After the write with count==DMA_LEN-1, state <= Idle.
- Source mapping: src_hi = dma_reg; if dma_reg >= 0xE0, src_hi = dma_reg - 0x20 (echo-RAM mirror). dma_reg readback is unmodified.
- Timing: trigger at end of M-cycle N. M-cycle N+1 is Start. Transfers occur in N+2..N+161. Idle begins at N+162.
- dma_active = (state==Active) | (state==Start & restart). A restart mid-copy therefore keeps the bus blocked through the delay M-cycle.
- CPU routing (combinational):
  - cpu_addr[15:8]==0xFF: goes to the high bus (enable/write/data pass-through) regardless of DMA. A CPU read of DMA_REG_ADDR returns dma_reg (high_enable=0).
  - Otherwise, dma_active=0: main bus = CPU signals.
  - Otherwise, dma_active=1: the CPU access is not issued, cpu_data_in=0xFF, and writes are dropped.
- cpu_data_in mux: dma_reg for FF46, else high_data_in for 0xFFxx, else 0xFF when blocked, else main_data_in.
- Simultaneous events:
  - A trigger in the same M-cycle as the final transfer: the final OAM write still occurs, then the next state is Start (trigger wins).
  - A CPU access while state==Start with restart=0 is not blocked.
- count is 8-bit and never wraps past DMA_LEN-1.

Decomposition:
- Shared package cpu_pkg: state typedef dma_state_e {DmaIdle, DmaStart, DmaActive}, plus constants DMA_REG_ADDR, DMA_LEN, HIGH_PAGE (8'hFF), and ECHO_BASE (8'hE0).
- The bus-routing mux is kept in this module.
- One natural sub-module: oam_dma_engine (state machine, counter, dma_reg, OAM port). The top level does routing and readback.

Test Plan:
- Write 0xC1 to FF46 with main memory C100+i = i^0x5A:
  - oam_write pulses 160 times with oam_addr 0..159 and data i^0x5A.
  - The first pulse is in M-cycle N+2; Idle is reached at N+162.
- During Active, CPU reads 0x0150 -> 0xFF, and a CPU write to C000 is not seen on main_write. A CPU write/read of FF80 (0x3C) succeeds via the high bus.
- Write 0xE2 to FF46:
  - main_addr sweeps C200..C29F.
  - A CPU read of FF46 returns 0xE2.
- Restart: write 0xC0, then 0xD0 during the transfer at count=50:
  - dma_active stays 1 through the Start M-cycle.
  - The next OAM write is oam_addr=0 with data from D000.
- Deassert reset_n at count=80 (mid-M-cycle):
  - oam_write=0 and dma_active=0 immediately.
  - A FF46 read returns 0x00.
  - The CPU read of 0x0000 passes through.
- A trigger coincident with the count=159 write: write 159 occurs, Start follows, and a new count=0 transfer follows at the next M-cycle.
